dec_bin_encoder: RTL and testbench
==================================

// Module: dec_bin_encoder
// PURPOSE
//  Reverse path of the binary-to-decimal line decoder: takes 10 active-low decimal lines
//  (keypad/switch bank, line i low = digit i) and returns a debounced 4-bit binary digit.
//  Synchronises and debounces the lines, then priority-encodes them.
//  Emits one event per press on a valid/ready handshake to downstream logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive stable cycles required to accept a press or release (>=2)
//  CNT_W             5  debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk      in   1   system clock, all logic on rising edge
//  rst_n    in   1   synchronous reset, active-low
//  key_n    in  10   asynchronous decimal lines, active-low; bit i = digit i
//  ready    in   1   downstream accepts the event when high with valid
//  valid    out  1   event present; code and multi stable while high
//  code     out  4   binary digit 0..9 of lowest-index active line
//  multi    out  1   more than one line was active in the accepted snapshot
//  busy     out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n low at an edge): sync flops = 10'h3FF, state=IDLE, cnt=0, snapshot=0,
//   valid=0, code=0, multi=0, busy=0. Reset wins over every other condition, including mid-handshake.
//  Input path: 2-flop synchroniser on key_n -> key_s; active = ~key_s (10 bits).
//  States: IDLE, DEBOUNCE, EMIT, RELEASE.
//  IDLE: active!=0 -> DEBOUNCE, snapshot<=active, cnt<=0.
//  DEBOUNCE, per edge:
//   - active==0 -> IDLE.
//   - else if active!=snapshot -> snapshot<=active, cnt<=0.
//   - else if cnt==DEBOUNCE_CYCLES-1 -> EMIT, valid<=1, code<=enc(snapshot), multi<=popcount>1.
//   - else cnt<=cnt+1.
//  enc(): index of lowest set bit (bit0 highest priority), 4-bit result 0..9.
//  EMIT:
//   - valid high; code/multi held constant regardless of key_n.
//   - valid&&ready at an edge -> valid<=0, RELEASE, cnt<=0.
//   - ready may be high before valid; no combinational ready->valid path.
//  RELEASE, per edge:
//   - active!=0 -> cnt<=0.
//   - else if cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//   - else cnt<=cnt+1.
//   - No new event until all lines are released for DEBOUNCE_CYCLES cycles (no auto-repeat).
//  Latency: key_n settles before edge 1 -> valid high after edge DEBOUNCE_CYCLES+3 (ready=1).
//  Exactly one valid&&ready transfer per accepted press; events are never dropped or duplicated.
//  Extra lines pressed during EMIT/RELEASE are ignored until full release.
//  Counter never wraps: it is cleared on every state entry and capped by DEBOUNCE_CYCLES-1.
// TESTING (DEBOUNCE_CYCLES=4 unless noted)
//  1 key_n[7]=0 stable, ready=1 -> valid=1 for one cycle after edge 7, code=7, multi=0.
//  2 key_n[3] toggles every 2 cycles for 12 cycles, then stays low -> exactly one event, code=3.
//  3 key_n[2] and key_n[5] low together -> code=2, multi=1, single event.
//  4 key 4 pressed, ready=0 for 20 cycles -> valid/code held 4; ready=1 -> valid=0 next edge.
//    Key still held -> no second event.
//  5 key 1 held 50 cycles, released 4 cycles, then key 9 pressed -> two events: code=1, code=9.
//    Release of only 2 cycles between presses -> second press not reported until full release.
//  6 rst_n=0 one edge during EMIT with key 6 held -> valid=0, busy=0 next cycle.
//    After reset, key 6 still held -> new event code=6 after the full latency.

Source files
------------

// File: rtl/dec_bin_encoder.sv
// Debounced priority encoder for 10 active-low decimal key lines.
// Emits one {code, multi} event per accepted press on a valid/ready handshake.
module dec_bin_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key_n,
    input  logic       ready,
    output logic       valid,
    output logic [3:0] code,
    output logic       multi,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, RELEASE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       snapshot;
    logic [9:0]       sync_p0;
    logic [9:0]       sync_p1;
    logic [9:0]       active;

    // Lowest set bit wins: scanning downward lets the smaller index overwrite.
    function automatic logic [3:0] enc(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic more_than_one(input logic [9:0] v);
        return (v & (v - 10'd1)) != 10'd0;
    endfunction

    assign active = ~sync_p1;

    // Stage p0/p1: two-flop synchroniser on the asynchronous key lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 10'h3FF;
            sync_p1 <= 10'h3FF;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce / handshake FSM on the synchronised lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            snapshot <= '0;
            valid    <= 1'b0;
            code     <= 4'd0;
            multi    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (active != 10'd0) begin
                        state    <= DEBOUNCE;
                        snapshot <= active;
                        cnt      <= '0;
                        busy     <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (active == 10'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (active != snapshot) begin
                        snapshot <= active;
                        cnt      <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= EMIT;
                        valid <= 1'b1;
                        code  <= enc(snapshot);
                        multi <= more_than_one(snapshot);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EMIT: begin
                    if (valid && ready) begin
                        valid <= 1'b0;
                        state <= RELEASE;
                        cnt   <= '0;
                    end
                end
                RELEASE: begin
                    // Any held line restarts the release window, so there is no auto-repeat.
                    if (active != 10'd0) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_bin_encoder.sv
// Directed bench for dec_bin_encoder with a scoreboard of expected events.
module tb_dec_bin_encoder;

    logic       clk;
    logic       rst_n;
    logic [9:0] key_n;
    logic       ready;
    logic       valid;
    logic [3:0] code;
    logic       multi;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ev_cnt = 0;
    int exp_ev = 0;
    logic [4:0] sb[$];

    dec_bin_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .ready(ready),
        .valid(valid), .code(code), .multi(multi), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshake transfer must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            ev_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_event", {27'd0, code, multi}, 32'h1F);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                chk("ev_code", {28'd0, code}, {28'd0, e[4:1]});
                chk("ev_multi", {31'd0, multi}, {31'd0, e[0]});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [3:0] c, input logic m);
        sb.push_back({c, m});
        exp_ev++;
    endtask

    task automatic wait_event(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                idle = 1'b1;
                break;
            end
            tick(1);
        end
        chk(tag, {31'd0, idle}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 10'h3FF;
        ready = 1'b1;
        tick(3);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_code", {28'd0, code}, 32'd0);
        chk("rst_multi", {31'd0, multi}, 32'd0);

        // Test 1: single key 7, exact latency
        rst_n = 1'b1;
        key_n = ~(10'd1 << 7);
        expect_ev(4'd7, 1'b0);
        tick(6);
        chk("t1_valid_e6", {31'd0, valid}, 32'd0);
        tick(1);
        chk("t1_valid_e7", {31'd0, valid}, 32'd1);
        chk("t1_code", {28'd0, code}, 32'd7);
        chk("t1_multi", {31'd0, multi}, 32'd0);
        tick(1);
        chk("t1_valid_e8", {31'd0, valid}, 32'd0);
        chk("t1_busy_release", {31'd0, busy}, 32'd1);
        key_n = 10'h3FF;
        wait_idle("t1_idle");
        chk("t1_events", ev_cnt, exp_ev);

        // Test 2: bouncing key 3 settles low
        for (int i = 0; i < 3; i++) begin
            key_n = ~(10'd1 << 3);
            tick(2);
            key_n = 10'h3FF;
            tick(2);
        end
        chk("t2_no_early_event", ev_cnt, exp_ev);
        key_n = ~(10'd1 << 3);
        expect_ev(4'd3, 1'b0);
        wait_event("t2_event");
        tick(10);
        key_n = 10'h3FF;
        wait_idle("t2_idle");
        chk("t2_events", ev_cnt, exp_ev);

        // Test 3: keys 2 and 5 together
        key_n = ~((10'd1 << 2) | (10'd1 << 5));
        expect_ev(4'd2, 1'b1);
        wait_event("t3_event");
        chk("t3_code", {28'd0, code}, 32'd2);
        chk("t3_multi", {31'd0, multi}, 32'd1);
        tick(5);
        key_n = 10'h3FF;
        wait_idle("t3_idle");
        chk("t3_events", ev_cnt, exp_ev);

        // Test 4: backpressure holds the event, extra key ignored
        ready = 1'b0;
        key_n = ~(10'd1 << 4);
        expect_ev(4'd4, 1'b0);
        wait_event("t4_event");
        for (int i = 0; i < 20; i++) begin
            if (i == 5) key_n = ~((10'd1 << 4) | 10'd1);
            tick(1);
            chk("t4_hold_valid", {31'd0, valid}, 32'd1);
            chk("t4_hold_code", {28'd0, code}, 32'd4);
        end
        ready = 1'b1;
        tick(1);
        chk("t4_valid_drop", {31'd0, valid}, 32'd0);
        tick(30);
        chk("t4_no_repeat", ev_cnt, exp_ev);
        chk("t4_busy_held", {31'd0, busy}, 32'd1);
        key_n = 10'h3FF;
        wait_idle("t4_idle");

        // Test 5: key 1 then key 9 after exactly four released cycles
        key_n = ~(10'd1 << 1);
        expect_ev(4'd1, 1'b0);
        tick(50);
        key_n = 10'h3FF;
        tick(4);
        key_n = ~(10'd1 << 9);
        expect_ev(4'd9, 1'b0);
        wait_event("t5_event9");
        tick(5);
        chk("t5_two_events", ev_cnt, exp_ev);
        key_n = 10'h3FF;
        wait_idle("t5_idle_a");
        key_n = ~(10'd1 << 1);
        expect_ev(4'd1, 1'b0);
        wait_event("t5_event1b");
        tick(5);
        key_n = 10'h3FF;
        tick(2);
        key_n = ~(10'd1 << 9);
        tick(30);
        chk("t5_short_release", ev_cnt, exp_ev);
        chk("t5_busy_short", {31'd0, busy}, 32'd1);
        key_n = 10'h3FF;
        wait_idle("t5_idle_b");
        key_n = ~(10'd1 << 9);
        expect_ev(4'd9, 1'b0);
        wait_event("t5_event9b");
        tick(3);
        key_n = 10'h3FF;
        wait_idle("t5_idle_c");
        chk("t5_events", ev_cnt, exp_ev);

        // Test 6: reset during EMIT, then full latency again
        ready = 1'b0;
        key_n = ~(10'd1 << 6);
        wait_event("t6_pre_event");
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("t6_rst_valid", {31'd0, valid}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        ready = 1'b1;
        expect_ev(4'd6, 1'b0);
        tick(6);
        chk("t6_valid_e6", {31'd0, valid}, 32'd0);
        tick(1);
        chk("t6_valid_e7", {31'd0, valid}, 32'd1);
        chk("t6_code", {28'd0, code}, 32'd6);
        tick(1);
        chk("t6_valid_e8", {31'd0, valid}, 32'd0);
        key_n = 10'h3FF;
        wait_idle("t6_idle");

        chk("final_events", ev_cnt, exp_ev);
        chk("final_sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
